hub75_scan_ctrl: RTL

Scan controller for the 64x32 HUB75 panel. It sequences a combinational pixel source that is addressed by line[4:0] and column[5:0] and returns r1/g1/b1 for the upper half and r2/g2/b2 for the lower half. For each of 32 row pairs it shifts 64 columns into the panel, blanks, latches, then enables display for a fixed on-time. It sits between any pattern LUT (for example the ring generators) and the board pins.

---
 rtl/hub75_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller for a 64x32 panel (two 32-row halves).
// Each row pair is shifted, blanked, latched and then displayed for a
// fixed on-time. The pixel source is combinational and is addressed one
// cycle ahead of the pins, so the fetched pixel is registered on the same
// edge that moves the pins to the next column.
module hub75_scan_ctrl #(
    parameter int CLK_DIV      = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int OE_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [4:0] line,
    output logic [5:0] column,
    input  logic       r1,
    input  logic       g1,
    input  logic       b1,
    input  logic       r2,
    input  logic       g2,
    input  logic       b2,
    output logic       hub_r1,
    output logic       hub_g1,
    output logic       hub_b1,
    output logic       hub_r2,
    output logic       hub_g2,
    output logic       hub_b2,
    output logic       hub_clk,
    output logic       hub_lat,
    output logic       hub_oe_n,
    output logic [4:0] hub_addr,
    output logic       frame_done
);

    // Phase counter spans one full hub_clk period (2*CLK_DIV cycles).
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    // One shared counter serves both BLANK and DISPLAY.
    localparam int CMAX = (BLANK_CYCLES > OE_CYCLES) ? BLANK_CYCLES : OE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'(2 * CLK_DIV - 2);
    localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] OE_LAST    = CW'(OE_CYCLES - 1);
    // Only meaningful when OE_CYCLES >= 2; the LATCH state covers OE_CYCLES == 1.
    localparam logic [CW-1:0] OE_PRE     = CW'((OE_CYCLES >= 2) ? OE_CYCLES - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t        state_reg;
    logic [4:0]    row_reg;
    logic [4:0]    line_reg;
    logic [5:0]    column_reg;
    logic [5:0]    col_idx_reg;
    logic [PW-1:0] phase_reg;
    logic [PW-1:0] phase_inc;
    logic [CW-1:0] cnt_reg;
    logic [5:0]    data_reg;
    logic [5:0]    pix_in;
    logic          hub_clk_reg;
    logic          hub_lat_reg;
    logic          hub_oe_n_reg;
    logic [4:0]    hub_addr_reg;
    logic          frame_done_reg;

    assign phase_inc = phase_reg + PW'(1);

    // Pixel bus order: {r1, g1, b1, r2, g2, b2}
    assign pix_in = {r1, g1, b1, r2, g2, b2};

    // Scan sequencer: all pins and source addresses are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            row_reg        <= 5'd0;
            line_reg       <= 5'd0;
            column_reg     <= 6'd0;
            col_idx_reg    <= 6'd0;
            phase_reg      <= '0;
            cnt_reg        <= '0;
            data_reg       <= 6'd0;
            hub_clk_reg    <= 1'b0;
            hub_lat_reg    <= 1'b0;
            hub_oe_n_reg   <= 1'b1;
            hub_addr_reg   <= 5'd0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    hub_oe_n_reg <= 1'b1;
                    hub_clk_reg  <= 1'b0;
                    hub_lat_reg  <= 1'b0;
                    if (enable) begin
                        state_reg   <= SHIFT;
                        phase_reg   <= '0;
                        col_idx_reg <= 6'd0;
                        data_reg    <= pix_in;
                    end
                end
                SHIFT: begin
                    if (phase_reg == PH_LAST) begin
                        phase_reg   <= '0;
                        hub_clk_reg <= 1'b0;
                        if (col_idx_reg == 6'd63) begin
                            // Last column shifted: data stays on the pins.
                            state_reg    <= BLANK;
                            cnt_reg      <= '0;
                            hub_addr_reg <= row_reg;
                        end else begin
                            col_idx_reg <= col_idx_reg + 6'd1;
                            data_reg    <= pix_in;
                        end
                    end else begin
                        phase_reg   <= phase_inc;
                        hub_clk_reg <= (phase_inc >= PH_HI);
                        // Address the next column one cycle before it is sampled;
                        // after column 63 this wraps to 0, ready for the next row.
                        if (phase_reg == PH_PRE) begin
                            column_reg <= col_idx_reg + 6'd1;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg   <= LATCH;
                        hub_lat_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                LATCH: begin
                    state_reg    <= DISPLAY;
                    hub_lat_reg  <= 1'b0;
                    hub_oe_n_reg <= 1'b0;
                    cnt_reg      <= '0;
                    if (OE_CYCLES == 1) begin
                        line_reg <= row_reg + 5'd1;
                    end
                end
                DISPLAY: begin
                    if (cnt_reg == OE_LAST) begin
                        hub_oe_n_reg   <= 1'b1;
                        row_reg        <= row_reg + 5'd1;
                        frame_done_reg <= (row_reg == 5'd31);
                        if (enable) begin
                            // The next row's column 0 was addressed during this cycle.
                            state_reg   <= SHIFT;
                            phase_reg   <= '0;
                            col_idx_reg <= 6'd0;
                            data_reg    <= pix_in;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (OE_CYCLES >= 2 && cnt_reg == OE_PRE) begin
                            line_reg <= row_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    hub_oe_n_reg <= 1'b1;
                    hub_clk_reg  <= 1'b0;
                    hub_lat_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign line       = line_reg;
    assign column     = column_reg;
    assign hub_r1     = data_reg[5];
    assign hub_g1     = data_reg[4];
    assign hub_b1     = data_reg[3];
    assign hub_r2     = data_reg[2];
    assign hub_g2     = data_reg[1];
    assign hub_b2     = data_reg[0];
    assign hub_clk    = hub_clk_reg;
    assign hub_lat    = hub_lat_reg;
    assign hub_oe_n   = hub_oe_n_reg;
    assign hub_addr   = hub_addr_reg;
    assign frame_done = frame_done_reg;

endmodule
